// File: rtl/riscv_lsu_pkg.sv
`default_nettype none
// ============================================================================
// riscv_lsu_pkg : shared types and request-legality helpers for the LSU
// Revision 1.0
// ============================================================================
package riscv_lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_RESP = 2'b11
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_FUNCT3   = 2'b10,
      ERR_TIMEOUT  = 2'b11
   } lsu_err_e;

   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we)
         return f3[2];
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   // Width is encoded in funct3[1:0]; byte accesses are always aligned.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      case (f3[1:0])
         2'b01:   return addr_lo[0];
         2'b10:   return addr_lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_lsu_align.sv
`default_nettype none
// ============================================================================
// riscv_lsu_align : byte enables, store lane replication, load shift/extend
// Revision 1.0
// ============================================================================
module riscv_lsu_align
   import riscv_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] load_raw,
   output logic [3:0]  be,
   output logic [31:0] store_lanes,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   always_comb begin
      shifted     = load_raw >> {addr_lo, 3'b000};
      be          = 4'b1111;
      store_lanes = store_data;
      load_data   = shifted;

      case (funct3[1:0])
         2'b00: begin
            be          = 4'b0001 << addr_lo;
            store_lanes = {4{store_data[7:0]}};
         end
         2'b01: begin
            be          = addr_lo[1] ? 4'b1100 : 4'b0011;
            store_lanes = {2{store_data[15:0]}};
         end
         default: begin
            be          = 4'b1111;
            store_lanes = store_data;
         end
      endcase

      case (funct3)
         F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   load_data = {24'd0, shifted[7:0]};
         F3_HU:   load_data = {16'd0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// riscv_lsu : RV32I load/store unit driving a req/gnt/rvalid data bus
// Revision 1.0
// ============================================================================
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        a_rst,
   input  logic        lsu_valid,
   input  logic        lsu_we,
   input  logic [2:0]  lsu_funct3,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic        lsu_ready,
   output logic        lsu_busy,
   output logic        lsu_done,
   output logic        lsu_err,
   output logic [1:0]  lsu_err_code,
   output logic [31:0] lsu_rdata,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

   lsu_state_e  state;
   lsu_err_e    err_q;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [9:0]  cnt;

   logic [3:0]  be_w;
   logic [31:0] lanes_w;
   logic [31:0] ext_w;

   riscv_lsu_align u_align (
      .funct3      (f3_q),
      .addr_lo     (addr_q[1:0]),
      .store_data  (wdata_q),
      .load_raw    (mem_rdata),
      .be          (be_w),
      .store_lanes (lanes_w),
      .load_data   (ext_w)
   );

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         state   <= ST_IDLE;
         err_q   <= ERR_NONE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         cnt     <= 10'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (lsu_valid) begin
                  we_q    <= lsu_we;
                  f3_q    <= lsu_funct3;
                  addr_q  <= lsu_addr;
                  wdata_q <= lsu_wdata;
                  rdata_q <= 32'd0;
                  cnt     <= 10'd0;
                  if (f3_illegal(lsu_we, lsu_funct3)) begin
                     err_q <= ERR_FUNCT3;
                     state <= ST_RESP;
                  end else if (is_misaligned(lsu_funct3, lsu_addr[1:0])) begin
                     err_q <= ERR_MISALIGN;
                     state <= ST_RESP;
                  end else begin
                     err_q <= ERR_NONE;
                     state <= ST_REQ;
                  end
               end
            end
            // Timeout wins over a grant or response arriving in its final cycle.
            ST_REQ: begin
               cnt <= cnt + 10'd1;
               if (cnt == TMO_LAST) begin
                  err_q <= ERR_TIMEOUT;
                  state <= ST_RESP;
               end else if (mem_gnt) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt <= cnt + 10'd1;
               if (cnt == TMO_LAST) begin
                  err_q <= ERR_TIMEOUT;
                  state <= ST_RESP;
               end else if (mem_rvalid) begin
                  rdata_q <= we_q ? 32'd0 : ext_w;
                  state   <= ST_RESP;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign lsu_ready    = (state == ST_IDLE);
   assign lsu_done     = (state == ST_RESP);
   assign lsu_busy     = lsu_valid & ~lsu_done;
   assign lsu_err      = lsu_done & (err_q != ERR_NONE);
   assign lsu_err_code = lsu_done ? err_q : ERR_NONE;
   assign lsu_rdata    = lsu_done ? rdata_q : 32'd0;

   // Bus outputs are driven only while requesting, so reset clears them at once.
   assign mem_req   = (state == ST_REQ);
   assign mem_we    = mem_req & we_q;
   assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
   assign mem_be    = mem_req ? be_w : 4'b0000;
   assign mem_wdata = (mem_req & we_q) ? lanes_w : 32'd0;

endmodule
`default_nettype wire
